// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic int cnt_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/cla_slice_seq_ctrl_add_slice.sv
// 4-bit carry-lookahead adder slice: generate/propagate carry network plus XOR sum gates.
module add_slice_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum-of-products of c_in, so no ripple inside the slice.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

endmodule

// File: rtl/cla_slice_seq_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single shared 4-bit CLA slice.
module cla_slice_seq_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_w(NSLICE);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               last;
    logic [IDX_W-1:0]   base;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_c;

    assign accept = in_valid && in_ready;
    assign last   = (count_q == LAST);
    assign base   = IDX_W'(SLICE_W * int'(count_q));
    assign sl_a   = opa_q[base +: SLICE_W];
    assign sl_b   = opb_q[base +: SLICE_W];

    add_slice_4b u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry_q),
        .s     (sl_s),
        .c_out (sl_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so nothing can be accepted during a reset cycle.
    always_comb begin
        in_ready  = rst_n && (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                sum_d[base +: SLICE_W] = sl_s;
                carry_d = sl_c;
                count_d = count_q + CNT_W'(1);
                if (last) begin
                    count_d = '0;
                    cout_d  = sl_c;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum_d[WIDTH-1] != opa_q[WIDTH-1]);
                    zero_d  = (sum_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        if (!rst_n) begin
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_cla_slice_seq_ctrl.sv
// Bench for cla_slice_seq_ctrl: directed table, handshake corner sequences and random ops against an arithmetic model.
module tb_cla_slice_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_slice_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed and unsigned results computed as plain integers.
    function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                  input logic sv, output logic [15:0] r, output logic co,
                                  output logic ov, output logic z);
        int unsigned ua, ub, ur;
        int sa, sb, sr;
        ua = 32'(av);
        ub = 32'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (sv) begin
            ur = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + 32'(cv);
            co = (ur > 32'd65535);
            sr = sa + sb + int'(cv);
        end
        r  = ur[15:0];
        ov = (sr > 32767) || (sr < -32768);
        z  = (r == 16'h0000);
    endfunction

    task automatic do_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input logic [15:0] es,
                         input logic eco, input logic eov, input logic ez);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd4);
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(eco));
        chk({nm, " ovf"}, 32'(ovf), 32'(eov));
        chk({nm, " zero"}, 32'(zero), 32'(ez));
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " out_valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ms;
        logic        mco, mov, mz;
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [15:0] corner[6];
        int          w;
        int          seen;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h00FF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        tick(); tick(); tick();
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready_high", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                  tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z);
        end

        // Backpressure: result held, new operands on in_valid must be ignored.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        chk("bp latency", 32'(w), 32'd4);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp sum", 32'(sum), 32'h3333);
            chk("bp flags", {29'd0, cout, ovf, zero}, 32'd0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp idle out_valid", 32'(out_valid), 32'd0);
        chk("bp idle busy", 32'(busy), 32'd0);
        chk("bp idle in_ready", 32'(in_ready), 32'd1);
        do_op("bp next", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);

        // Reset two cycles into RUN discards the operation.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid sum", 32'(sum), 32'd0);
        chk("mid flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("mid out_valid", 32'(out_valid), 32'd0);
        chk("mid busy_clr", 32'(busy), 32'd0);
        chk("mid in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid in_ready_high", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid no out_valid", 32'(seen), 32'd0);
        do_op("post rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rc, rs, ms, mco, mov, mz);
            do_op($sformatf("rnd%0d %h %s %h c%0d", i, ra, rs ? "-" : "+", rb, rc),
                  ra, rb, rc, rs, ms, mco, mov, mz);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
